// File: rtl/regfile_wb_sched_if.sv
// Handshake and bus bundle between execute/memory, decode and the write-back scheduler.
// The slave modport is the scheduler's view; master is the surrounding pipeline's view.
interface regfile_wb_sched_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) ();
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_dest;
    logic              issue_ready;

    logic              src0_valid;
    logic [ADDR_W-1:0] src0_dest;
    logic [DATA_W-1:0] src0_data;
    logic              src0_ready;

    logic              src1_valid;
    logic [ADDR_W-1:0] src1_dest;
    logic [DATA_W-1:0] src1_data;
    logic              src1_ready;

    logic              reg_write_e;
    logic [ADDR_W-1:0] reg_write_dest;
    logic [DATA_W-1:0] reg_write_data;

    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr2;
    logic              hazard;
    logic              hazard2;
    logic              wb_err;

    modport slave (
        input  issue_valid, issue_dest,
        output issue_ready,
        input  src0_valid, src0_dest, src0_data,
        output src0_ready,
        input  src1_valid, src1_dest, src1_data,
        output src1_ready,
        output reg_write_e, reg_write_dest, reg_write_data,
        input  rd_addr, rd_addr2,
        output hazard, hazard2, wb_err
    );

    modport master (
        output issue_valid, issue_dest,
        input  issue_ready,
        output src0_valid, src0_dest, src0_data,
        input  src0_ready,
        output src1_valid, src1_dest, src1_data,
        input  src1_ready,
        input  reg_write_e, reg_write_dest, reg_write_data,
        output rd_addr, rd_addr2,
        input  hazard, hazard2, wb_err
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin write-back arbiter for the register file write port, with a
// per-register outstanding-write scoreboard feeding decode hazard detection.
module regfile_wb_sched #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_wb_sched_if.slave  bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic              we_q, we_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rr_q, rr_d;
    logic              err_q, err_d;

    logic              gnt0, gnt1;
    logic              dec_hit, issue_ok;
    logic [NREG-1:0]   inc_v, dec_v;

    // rr_q names the favoured source when both request; it flips to the other one on each grant
    always_comb begin
        gnt0   = bus.src0_valid & (~bus.src1_valid | ~rr_q);
        gnt1   = bus.src1_valid & (~bus.src0_valid |  rr_q);
        rr_d   = rr_q;
        we_d   = gnt0 | gnt1;
        dest_d = dest_q;
        data_d = data_q;
        if (gnt1) begin
            rr_d   = 1'b0;
            dest_d = bus.src1_dest;
            data_d = bus.src1_data;
        end else if (gnt0) begin
            rr_d   = 1'b1;
            dest_d = bus.src0_dest;
            data_d = bus.src0_data;
        end
    end

    // A write leaving the pipe this cycle frees a slot, so a saturated register may still accept an issue
    always_comb begin
        dec_hit  = we_q && (dest_q == bus.issue_dest);
        issue_ok = (cnt_q[bus.issue_dest] != CNT_MAX) || dec_hit;
        err_d    = err_q | (we_q && (cnt_q[dest_q] == '0));
        inc_v    = '0;
        dec_v    = '0;
        for (int r = 0; r < NREG; r++) begin
            inc_v[r] = bus.issue_valid && issue_ok && (bus.issue_dest == ADDR_W'(r));
            dec_v[r] = we_q && (dest_q == ADDR_W'(r));
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
            rr_q   <= 1'b0;
            err_q  <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            we_q   <= we_d;
            dest_q <= dest_d;
            data_q <= data_d;
            rr_q   <= rr_d;
            err_q  <= err_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign bus.src0_ready     = gnt0;
    assign bus.src1_ready     = gnt1;
    assign bus.issue_ready    = issue_ok;
    assign bus.reg_write_e    = we_q;
    assign bus.reg_write_dest = dest_q;
    assign bus.reg_write_data = data_q;
    assign bus.hazard         = (cnt_q[bus.rd_addr]  != '0);
    assign bus.hazard2        = (cnt_q[bus.rd_addr2] != '0);
    assign bus.wb_err         = err_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus randomized traffic, all
// checked against a counting model of outstanding writes and a queued write port.
module tb_regfile_wb_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_sched_if #(.DATA_W(16), .ADDR_W(4)) bus ();

    regfile_wb_sched #(.DATA_W(16), .ADDR_W(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding writes per register, the value on the write port, last winner
    int m_cnt [16];
    bit m_we;
    int m_dest;
    int m_data;
    bit m_err;
    int m_last;
    bit g0_q, g1_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_we = 0; m_dest = 0; m_data = 0; m_err = 0;
        m_last = 1;
    endtask

    task automatic drive_idle();
        bus.issue_valid = 0; bus.issue_dest = '0;
        bus.src0_valid = 0; bus.src0_dest = '0; bus.src0_data = '0;
        bus.src1_valid = 0; bus.src1_dest = '0; bus.src1_data = '0;
        bus.rd_addr = '0; bus.rd_addr2 = '0;
    endtask

    // Called at a falling edge with inputs set: checks every output, advances the model one cycle
    task automatic tick();
        bit g0, g1, ir;
        int id;
        #1;
        id = int'(bus.issue_dest);
        g0 = bus.src0_valid && (!bus.src1_valid || m_last == 1);
        g1 = bus.src1_valid && (!bus.src0_valid || m_last == 0);
        ir = !(m_cnt[id] == 3 && !(m_we && m_dest == id));
        chk("src0_ready", 32'(bus.src0_ready), 32'(g0));
        chk("src1_ready", 32'(bus.src1_ready), 32'(g1));
        chk("issue_ready", 32'(bus.issue_ready), 32'(ir));
        chk("reg_write_e", 32'(bus.reg_write_e), 32'(m_we));
        chk("reg_write_dest", 32'(bus.reg_write_dest), m_dest);
        chk("reg_write_data", 32'(bus.reg_write_data), m_data);
        chk("wb_err", 32'(bus.wb_err), 32'(m_err));
        chk("hazard", 32'(bus.hazard), 32'(m_cnt[int'(bus.rd_addr)] != 0));
        chk("hazard2", 32'(bus.hazard2), 32'(m_cnt[int'(bus.rd_addr2)] != 0));
        if (m_we && m_cnt[m_dest] == 0) m_err = 1;
        if (bus.issue_valid && ir) m_cnt[id] += 1;
        if (m_we && m_cnt[m_dest] > 0) m_cnt[m_dest] -= 1;
        g0_q = g0;
        g1_q = g1;
        if (g0 || g1) begin
            m_we   = 1;
            m_dest = g1 ? int'(bus.src1_dest) : int'(bus.src0_dest);
            m_data = g1 ? int'(bus.src1_data) : int'(bus.src0_data);
            m_last = g1 ? 1 : 0;
        end else begin
            m_we = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_n = 0;
        #1;
        chk("rst_we", 32'(bus.reg_write_e), 32'd0);
        chk("rst_dest", 32'(bus.reg_write_dest), 32'd0);
        chk("rst_data", 32'(bus.reg_write_data), 32'd0);
        chk("rst_err", 32'(bus.wb_err), 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        drive_idle();
        @(negedge clk);
        apply_reset();

        // Mid-stream reset with src0 requesting
        bus.issue_valid = 1; bus.issue_dest = 4'd2;
        tick();
        bus.issue_valid = 0;
        bus.src0_valid = 1; bus.src0_dest = 4'd2; bus.src0_data = 16'hAAAA;
        bus.rd_addr = 4'd2; bus.rd_addr2 = 4'd2;
        tick();
        bus.src0_data = 16'h5555;
        rst_n = 0;
        #1;
        chk("midrst_we", 32'(bus.reg_write_e), 32'd0);
        chk("midrst_hazard", 32'(bus.hazard), 32'd0);
        chk("midrst_hazard2", 32'(bus.hazard2), 32'd0);
        chk("midrst_err", 32'(bus.wb_err), 32'd0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
        bus.src0_valid = 0;
        #1;
        chk("postrst_we", 32'(bus.reg_write_e), 32'd1);
        chk("postrst_data", 32'(bus.reg_write_data), 32'h5555);
        tick();

        // Single source with hazard tracking on register 5
        apply_reset();
        bus.rd_addr = 4'd5;
        bus.issue_valid = 1; bus.issue_dest = 4'd5;
        tick();
        bus.issue_valid = 0;
        bus.src0_valid = 1; bus.src0_dest = 4'd5; bus.src0_data = 16'hBEEF;
        #1;
        chk("single_ready", 32'(bus.src0_ready), 32'd1);
        chk("single_haz_n", 32'(bus.hazard), 32'd1);
        tick();
        bus.src0_valid = 0;
        #1;
        chk("single_we", 32'(bus.reg_write_e), 32'd1);
        chk("single_dest", 32'(bus.reg_write_dest), 32'd5);
        chk("single_data", 32'(bus.reg_write_data), 32'hBEEF);
        chk("single_haz_n1", 32'(bus.hazard), 32'd1);
        tick();
        chk("single_haz_n2", 32'(bus.hazard), 32'd0);
        chk("single_we_off", 32'(bus.reg_write_e), 32'd0);
        tick();

        // Contention from reset: src0 wins first, then alternation
        apply_reset();
        bus.src0_valid = 1; bus.src0_dest = 4'd1; bus.src0_data = 16'h0011;
        bus.src1_valid = 1; bus.src1_dest = 4'd2; bus.src1_data = 16'h0022;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_gnt0", 32'(bus.src0_ready), 32'(i % 2 == 0));
            tick();
            chk("cont_dest", 32'(bus.reg_write_dest), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_we", 32'(bus.reg_write_e), 32'd1);
        end
        drive_idle();
        tick();

        // Saturation on register 3, then issue while the write port drains it
        apply_reset();
        bus.rd_addr = 4'd3;
        for (int i = 0; i < 3; i++) begin
            bus.issue_valid = 1; bus.issue_dest = 4'd3;
            tick();
        end
        bus.issue_valid = 0; bus.issue_dest = 4'd3;
        #1;
        chk("sat_ready3", 32'(bus.issue_ready), 32'd0);
        bus.issue_dest = 4'd4;
        #1;
        chk("sat_ready4", 32'(bus.issue_ready), 32'd1);
        bus.issue_dest = 4'd3;
        bus.src0_valid = 1; bus.src0_dest = 4'd3; bus.src0_data = 16'h0033;
        tick();
        bus.src0_valid = 0;
        bus.issue_valid = 1; bus.issue_dest = 4'd3;
        #1;
        chk("sat_ready_dec", 32'(bus.issue_ready), 32'd1);
        tick();
        bus.issue_valid = 0;
        #1;
        chk("sat_still_full", 32'(bus.issue_ready), 32'd0);
        chk("sat_err", 32'(bus.wb_err), 32'd0);
        tick();

        // Issue and write-back to register 7 in the same cycle
        bus.rd_addr2 = 4'd7;
        bus.issue_valid = 1; bus.issue_dest = 4'd7;
        tick();
        bus.issue_valid = 0;
        bus.src1_valid = 1; bus.src1_dest = 4'd7; bus.src1_data = 16'h0077;
        tick();
        bus.src1_valid = 0;
        bus.issue_valid = 1; bus.issue_dest = 4'd7;
        tick();
        bus.issue_valid = 0;
        #1;
        chk("simul_haz7", 32'(bus.hazard2), 32'd1);
        tick();
        chk("simul_haz7_hold", 32'(bus.hazard2), 32'd1);

        // Write-back to register 9 without an issue sets the sticky error
        apply_reset();
        bus.src1_valid = 1; bus.src1_dest = 4'd9; bus.src1_data = 16'h1234;
        tick();
        bus.src1_valid = 0;
        #1;
        chk("err_we", 32'(bus.reg_write_e), 32'd1);
        chk("err_dest", 32'(bus.reg_write_dest), 32'd9);
        chk("err_data", 32'(bus.reg_write_data), 32'h1234);
        chk("err_before", 32'(bus.wb_err), 32'd0);
        tick();
        chk("err_set", 32'(bus.wb_err), 32'd1);
        for (int i = 0; i < 3; i++) tick();
        chk("err_sticky", 32'(bus.wb_err), 32'd1);
        apply_reset();

        // Randomized traffic; sources hold requests until granted
        for (int blk = 0; blk < 4; blk++) begin
            apply_reset();
            for (int c = 0; c < 400; c++) begin
                if (!bus.src0_valid && $urandom_range(0, 4) == 0) begin
                    bus.src0_valid = 1;
                    bus.src0_dest  = 4'($urandom_range(0, 3));
                    bus.src0_data  = 16'($urandom);
                end
                if (!bus.src1_valid && $urandom_range(0, 4) == 0) begin
                    bus.src1_valid = 1;
                    bus.src1_dest  = 4'($urandom_range(0, 3));
                    bus.src1_data  = 16'($urandom);
                end
                bus.issue_valid = 1'($urandom_range(0, 1));
                bus.issue_dest  = 4'($urandom_range(0, 3));
                bus.rd_addr     = 4'($urandom_range(0, 4));
                bus.rd_addr2    = 4'($urandom_range(0, 4));
                tick();
                if (g0_q) bus.src0_valid = 0;
                if (g1_q) bus.src1_valid = 0;
            end
        end
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
